interrupt_cause_unit: RTL
=========================

// Module: interrupt_cause_unit
// PURPOSE
//  Collects internal exception causes and external interrupt lines, masks them with SR, and produces
//  jisr / mca / rpt for the special-purpose register block, which sits directly downstream.
//  External lines are synchronised and held pending until serviced.
//  jisr is issued only at an instruction-commit boundary, as a registered one-cycle pulse.
// PARAMETERS
//  N_EXT         16  number of external interrupt lines; mca width = 7+N_EXT (23 at default)
//  SYNC_STAGES   2   flip-flop synchroniser depth per external line (>=2)
//  FLUSH_CYCLES  2   cycles after a jisr pulse during which no new jisr may issue (>=1)
// PORTS
//  clk        in   1        system clock, rising edge
//  reset      in   1        asynchronous, active-high reset
//  commit     in   1        an instruction completes this cycle; internal causes are valid only then
//  c_ill      in   1        illegal instruction
//  c_mal      in   1        misaligned access
//  c_pff      in   1        page fault on fetch
//  c_pfls     in   1        page fault on load/store
//  c_sys      in   1        syscall/trap
//  c_ovf      in   1        arithmetic overflow
//  ext_irq    in   N_EXT    asynchronous device request lines, level
//  sr         in   32       status register; sr[6+N_EXT:6] masks causes 6..6+N_EXT
//  jisr       out  1        jump-to-ISR pulse, registered
//  mca        out  7+N_EXT  masked cause vector, valid while jisr=1, otherwise 0
//  rpt        out  1        1 = faulting instruction must be repeated (epc takes pc), valid with jisr
//  ext_ack    out  N_EXT    one-cycle acknowledge per external line, coincident with jisr
// BEHAVIOUR
//  Cause vector ca: [0]=reset, [1]=ill, [2]=mal, [3]=pff, [4]=pfls, [5]=sys, [6]=ovf, [7+i]=ext pending[i].
//  Masking: bits 0..5 are unmaskable; for bits 6..6+N_EXT, mca_n[k] = ca[k] & sr[k].
//  Internal bits 1..6 are taken from the inputs only when commit=1, and read as 0 otherwise.
//  External path:
//   - SYNC_STAGES flip-flops per line, then rising-edge detect.
//   - An edge sets pend[i]. pend[i] clears on the cycle ext_ack[i]=1.
//   - Edge and ack in the same cycle: the set wins, so pend stays 1.
//   - Masked pending bits stay pending and are not dropped.
//  Priority: il = lowest set index of mca_n; rpt_n = (il==3 || il==4).
//   mca still carries every set bit; only rpt uses priority.
//  FSM states:
//   - RST_IRQ: entered on reset. First cycle after reset release: jisr=1, mca=1 (bit0), rpt=0; go to FLUSH.
//   - IDLE: if |mca_n and (commit or any ext bit of mca_n set), register jisr=1, mca=mca_n, rpt=rpt_n,
//     ext_ack = mca_n[6+N_EXT:7]; go to FLUSH.
//     A pure-external interrupt may fire with commit=0; then rpt=0.
//   - FLUSH: jisr=0, mca=0, rpt=0, ext_ack=0. Count FLUSH_CYCLES, then go to IDLE.
//     Causes arriving here are ignored, except that external edges still latch into pend.
//  Latency: cause present in IDLE at cycle t -> jisr=1 at t+1. ext_irq edge -> pend set after SYNC_STAGES+1 cycles.
//  Reset values: jisr=0, mca=0, rpt=0, ext_ack=0, pend=0, sync chains=0, FSM=RST_IRQ.
//  Reset asserted mid-operation: all state clears immediately. Any pulse in flight is lost. RST_IRQ is re-entered.
//  SR change while a cause is pending: evaluated combinationally each IDLE cycle, no latching of sr.
//  jisr never holds for two consecutive cycles. mca is never nonzero while jisr=0.
// STRUCTURE
//  Shared package (interrupt defs):
//   - cause index localparams CA_RESET..CA_OVF and CA_EXT_BASE=7
//   - the REPEAT_MASK constant
//   - FSM state encoding {RST_IRQ, IDLE, FLUSH}
//  One sub-module: irq_sync_edge (SYNC_STAGES synchroniser + rising-edge detect), instantiated per line.
// TESTING
//  1. Release reset -> exactly one jisr cycle with mca=23'h1, rpt=0; then FLUSH_CYCLES idle; ext_ack=0.
//  2. commit=1, c_pff=1, c_ovf=1, sr=0 -> jisr, mca=23'h08, rpt=1 (ovf masked).
//  3. commit=1, c_ill=1, c_pfls=1 -> mca=23'h12, rpt=0 (ill has priority over pfls).
//  4. ext_irq[2] rises with sr[9]=0 -> pend held, no jisr. Set sr[9]=1 -> jisr with mca=23'h200 and
//     ext_ack=16'h0004 in the same cycle; pend[2] clears.
//  5. ext edge during FLUSH -> no jisr until IDLE. Then jisr with that bit; no cause is lost.
//  6. Assert reset while jisr=1 and pend nonzero -> outputs and pend are 0 at once. After release, RST_IRQ pulse only.

Source files
------------

// File: rtl/interrupt_cause_unit_pkg.sv
// Shared interrupt definitions: cause indices, the repeat mask and the FSM encoding.
package interrupt_cause_unit_pkg;

    // Positions of each cause in the cause vector ca / mca
    localparam int CA_RESET    = 0;
    localparam int CA_ILL      = 1;
    localparam int CA_MAL      = 2;
    localparam int CA_PFF      = 3;
    localparam int CA_PFLS     = 4;
    localparam int CA_SYS      = 5;
    localparam int CA_OVF      = 6;
    localparam int CA_EXT_BASE = 7;

    // Causes that force the faulting instruction to be repeated (page faults)
    localparam logic [6:0] REPEAT_MASK = 7'b001_1000;

    // Controller states
    localparam logic [1:0] ST_RST_IRQ = 2'd0;
    localparam logic [1:0] ST_IDLE    = 2'd1;
    localparam logic [1:0] ST_FLUSH   = 2'd2;

    // True when the isolated lowest-priority-index cause is a repeat cause
    function automatic logic is_repeat(input logic [6:0] low_onehot);
        return |(low_onehot & REPEAT_MASK);
    endfunction

endpackage

// File: rtl/interrupt_cause_unit_if.sv
// Cause inputs and jisr/mca/rpt/ext_ack outputs of the interrupt cause unit.
interface interrupt_cause_unit_if #(
    parameter int N_EXT = 16
);
    logic             commit;
    logic             c_ill;
    logic             c_mal;
    logic             c_pff;
    logic             c_pfls;
    logic             c_sys;
    logic             c_ovf;
    logic [N_EXT-1:0] ext_irq;
    logic [31:0]      sr;
    logic             jisr;
    logic [6+N_EXT:0] mca;
    logic             rpt;
    logic [N_EXT-1:0] ext_ack;

    // Pipeline side that supplies causes and consumes the jump request
    modport master (
        output commit, c_ill, c_mal, c_pff, c_pfls, c_sys, c_ovf, ext_irq, sr,
        input  jisr, mca, rpt, ext_ack
    );

    // The cause unit itself
    modport slave (
        input  commit, c_ill, c_mal, c_pff, c_pfls, c_sys, c_ovf, ext_irq, sr,
        output jisr, mca, rpt, ext_ack
    );
endinterface

// File: rtl/interrupt_cause_unit_irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line plus rising-edge detect.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_i,
    output logic rise_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // Shift the raw line through the synchroniser and remember the last synced value
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/interrupt_cause_unit.sv
// Interrupt cause unit: gathers internal and external causes, masks them with sr and
// issues a registered one-cycle jisr pulse with mca/rpt/ext_ack, followed by a flush gap.
module interrupt_cause_unit
    import interrupt_cause_unit_pkg::*;
#(
    parameter int N_EXT        = 16,
    parameter int SYNC_STAGES  = 2,
    parameter int FLUSH_CYCLES = 2
) (
    input logic                  clk,
    input logic                  reset,
    interrupt_cause_unit_if.slave bus
);
    localparam int CW    = CA_EXT_BASE + N_EXT;
    localparam int CNT_W = $clog2(FLUSH_CYCLES + 1);

    logic [N_EXT-1:0] ext_edge;
    logic [N_EXT-1:0] pend_q, pend_d;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jisr_q, jisr_d;
    logic [CW-1:0]    mca_q, mca_d;
    logic             rpt_q, rpt_d;
    logic [N_EXT-1:0] ack_q, ack_d;

    logic [6:0]       ca_int;
    logic [CW-1:0]    ca_mask;
    logic [CW-1:0]    mca_n;
    logic [CW-1:0]    low_onehot;
    logic             rpt_n;
    logic             fire;

    generate
        for (genvar gi = 0; gi < N_EXT; gi++) begin : g_ext
            irq_sync_edge #(
                .SYNC_STAGES(SYNC_STAGES)
            ) u_sync_edge (
                .clk    (clk),
                .reset  (reset),
                .async_i(bus.ext_irq[gi]),
                .rise_o (ext_edge[gi])
            );
        end
        if (CA_EXT_BASE + N_EXT < 32) begin : g_sr_hi
            logic unused_sr;
            assign unused_sr = ^{bus.sr[31:CA_EXT_BASE+N_EXT], bus.sr[CA_OVF-1:0]};
        end else begin : g_sr_lo
            logic unused_sr;
            assign unused_sr = ^bus.sr[CA_OVF-1:0];
        end
    endgenerate

    // Internal causes exist only on a commit boundary; bit 0 (reset) comes from the FSM
    assign ca_int  = bus.commit ? {bus.c_ovf, bus.c_sys, bus.c_pfls, bus.c_pff,
                                   bus.c_mal, bus.c_ill, 1'b0}
                                : 7'b0;
    assign ca_mask = {bus.sr[CA_OVF+N_EXT:CA_OVF], {CA_OVF{1'b1}}};
    assign mca_n   = {pend_q, ca_int} & ca_mask;

    // Isolate the lowest set bit; only rpt depends on priority
    assign low_onehot = mca_n & (~mca_n + {{(CW-1){1'b0}}, 1'b1});
    assign rpt_n      = is_repeat(low_onehot[6:0]);
    assign fire       = (|mca_n) & (bus.commit | (|mca_n[CW-1:CA_EXT_BASE]));

    // Next-state and output decode; pending edges latch in every state, set beats ack
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        jisr_d  = 1'b0;
        mca_d   = '0;
        rpt_d   = 1'b0;
        ack_d   = '0;
        case (state_q)
            ST_RST_IRQ: begin
                jisr_d  = 1'b1;
                mca_d   = {{(CW-1){1'b0}}, 1'b1};
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
            ST_IDLE: begin
                if (fire) begin
                    jisr_d  = 1'b1;
                    mca_d   = mca_n;
                    rpt_d   = rpt_n;
                    ack_d   = mca_n[CW-1:CA_EXT_BASE];
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end
            end
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pend_d = (pend_q & ~ack_d) | ext_edge;
    end

    // Register FSM, pending bits and all outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_RST_IRQ;
            cnt_q   <= '0;
            pend_q  <= '0;
            jisr_q  <= 1'b0;
            mca_q   <= '0;
            rpt_q   <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            jisr_q  <= jisr_d;
            mca_q   <= mca_d;
            rpt_q   <= rpt_d;
            ack_q   <= ack_d;
        end
    end

    assign bus.jisr    = jisr_q;
    assign bus.mca     = mca_q;
    assign bus.rpt     = rpt_q;
    assign bus.ext_ack = ack_q;
endmodule
